// File: rtl/bnn_reg_readback.sv
// Purpose: streams the BNN pixel array and weight set back out serially, one pixel bit and one weight bit per cycle.
// Latency: bit 0 appears the cycle after start is sampled; bit i follows i unpaused cycles later; done pulses one cycle after the last bit.
// Backpressure: pause high holds the stream (dout_valid drops next cycle, index and data hold) until pause is released.
module bnn_reg_readback #(
    parameter int IMG_DIM = 28,
    parameter int K_DIM   = 3,
    parameter int N_KERN  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              pause,
    input  logic [IMG_DIM*IMG_DIM-1:0]        pixels,
    input  logic [N_KERN*K_DIM*K_DIM-1:0]     weights,
    output logic                              dout_p,
    output logic                              dout_w,
    output logic                              dout_valid,
    output logic                              sof,
    output logic                              busy,
    output logic                              done
);

    localparam int N_PIX     = IMG_DIM * IMG_DIM;
    localparam int N_WGT     = N_KERN * K_DIM * K_DIM;
    localparam int IDX_W     = $clog2(N_PIX + 1);
    localparam int PIX_SEL_W = $clog2(N_PIX);
    localparam int WGT_SEL_W = $clog2(N_WGT);

    localparam logic [IDX_W-1:0] PIX_END = IDX_W'(N_PIX);
    localparam logic [IDX_W-1:0] WGT_END = IDX_W'(N_WGT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_dout_p;
    logic             r_dout_w;
    logic             r_valid;
    logic             r_sof;

    logic             w_load_first;
    logic             w_advance;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_pix_bit;
    logic             w_wgt_bit;

    // Next-state decode plus the bit-select for whichever stream position is loaded this edge.
    always_comb begin
        w_next_state = r_state;
        w_load_first = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load_first = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!pause) begin
                    if (r_idx < PIX_END) begin
                        w_advance = 1'b1;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // A fresh start always begins at bit 0, whatever the index was left at.
        w_sel_idx = w_load_first ? '0 : r_idx;
        w_pix_bit = pixels[w_sel_idx[PIX_SEL_W-1:0]];
        w_wgt_bit = (w_sel_idx < WGT_END) ? weights[w_sel_idx[WGT_SEL_W-1:0]] : 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output data, valid, start-of-frame and index registers; data and index hold whenever no bit is loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_dout_p <= 1'b0;
            r_dout_w <= 1'b0;
            r_valid  <= 1'b0;
            r_sof    <= 1'b0;
        end else begin
            if (w_load_first || w_advance) begin
                r_dout_p <= w_pix_bit;
                r_dout_w <= w_wgt_bit;
                r_idx    <= w_sel_idx + 1'b1;
                r_valid  <= 1'b1;
            end else begin
                r_valid  <= 1'b0;
            end
            r_sof <= w_load_first;
        end
    end

    assign dout_p     = r_dout_p;
    assign dout_w     = r_dout_w;
    assign dout_valid = r_valid;
    assign sof        = r_sof;
    assign busy       = (r_state == S_SHIFT);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_bnn_reg_readback.sv
// Bench for bnn_reg_readback: randomized streams against a bit-list reference model.
// Expected bits, sof cycles and done cycles are queued by the stimulus process.
// A negedge monitor pops and compares whenever the DUT presents a valid bit, sof or done.
module tb_bnn_reg_readback;

    localparam int NP = 784;
    localparam int NW = 72;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          pause;
    logic [NP-1:0] pixels;
    logic [NW-1:0] weights;
    logic          dout_p;
    logic          dout_w;
    logic          dout_valid;
    logic          sof;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic p;
        logic w;
        logic s;
        int   idx;
    } item_t;

    item_t exp_q[$];
    int    done_q[$];
    int    sof_q[$];

    bnn_reg_readback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .pixels     (pixels),
        .weights    (weights),
        .dout_p     (dout_p),
        .dout_w     (dout_w),
        .dout_valid (dout_valid),
        .sof        (sof),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: stream position i carries pixel i and, for i < 72, weight i.
    task automatic push_stream(input int n);
        for (int i = 0; i < n; i++) begin
            item_t it;
            it.p   = pixels[i];
            it.w   = (i < NW) ? weights[i] : 1'b0;
            it.s   = (i == 0);
            it.idx = i;
            exp_q.push_back(it);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout_p"}, dout_p, 0);
        chk({tag, "_dout_w"}, dout_w, 0);
        chk({tag, "_valid"},  dout_valid, 0);
        chk({tag, "_sof"},    sof, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NP; i++) pixels[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < NW; i++) weights[i] = 1'($urandom_range(0, 1));
    endtask

    // Called #1 after an edge with the DUT idle. Counts remaining bits to
    // predict when done must appear, given the pause pattern applied.
    task automatic run_stream(input int pmode, input bit hold);
        int rem;
        int k;
        bit p;
        push_stream(NP);
        sof_q.push_back(cyc + 1);
        start = 1'b1;
        pause = (pmode != 0);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        rem = NP - 1;
        k = 0;
        while (k < 5000) begin
            case (pmode)
                0:       p = 1'b0;
                1:       p = ((k / 3) % 2) == 1;
                3:       p = (rem == 0) && (k < NP + 2);
                default: p = ($urandom_range(0, 3) == 0);
            endcase
            pause = p;
            @(posedge clk); #1;
            k++;
            if (!p) begin
                if (rem > 0) begin
                    rem--;
                end else begin
                    done_q.push_back(cyc);
                    break;
                end
            end
        end
        if (k >= 5000) chk("stream_loop_bound", k, 0);
        pause = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_abort();
        push_stream(401);
        sof_q.push_back(cyc + 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("abort");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle_valid", dout_valid, 0);
    endtask

    // Monitor: compare every presented output event against the queues.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            chk("busy_with_valid", busy, 1);
            if (exp_q.size() == 0) begin
                chk("valid_with_empty_queue", dout_valid, 0);
            end else begin
                item_t it;
                it = exp_q.pop_front();
                chk($sformatf("dout_p[%0d]", it.idx), dout_p, it.p);
                chk($sformatf("dout_w[%0d]", it.idx), dout_w, it.w);
                chk($sformatf("sof[%0d]", it.idx), sof, it.s);
            end
            if (sof === 1'b1) begin
                if (sof_q.size() == 0) chk("sof_unexpected", sof, 0);
                else                   chk("sof_cycle", cyc, sof_q.pop_front());
            end
        end else if (cyc > 0) begin
            chk("sof_needs_valid", sof, 0);
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) chk("done_unexpected", done, 0);
            else                    chk("done_cycle", cyc, done_q.pop_front());
            chk("busy_in_done", busy, 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        pause   = 1'b0;
        pixels  = '0;
        weights = '0;

        // Reset held with start high: everything stays cleared.
        repeat (2) begin
            @(posedge clk); #1;
            chk_all_zero("reset");
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_valid", dout_valid, 0);
        chk("post_reset_busy", busy, 0);

        // Checkerboard pixels, A5 weights, no pause.
        for (int i = 0; i < NP; i++) pixels[i] = (i % 2) == 1;
        weights = {9{8'hA5}};
        run_stream(0, 1'b0);

        // Random data, pause toggling every third cycle.
        rand_data();
        run_stream(1, 1'b0);

        // start held high: second stream only from the IDLE cycle after done.
        rand_data();
        run_stream(0, 1'b1);
        run_stream(2, 1'b0);

        // Boundary pattern with pause held at the end of the stream.
        pixels = '1;
        pixels[NP-1] = 1'b0;
        weights = '0;
        weights[NW-1] = 1'b1;
        run_stream(3, 1'b0);

        // Abort mid-stream, then a clean restart.
        rand_data();
        run_abort();
        rand_data();
        run_stream(2, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        chk("sof_queue_drained", sof_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
